div32: RTL and testbench

Sequential signed 32-bit divider for the multicycle datapath. It takes two register operands, runs a one-bit-per-cycle restoring division, and presents the remainder on `hi` and the quotient on `lo`. Those two outputs feed the write-back data-source multiplexer directly, as its HI/LO inputs. It also flags divide-by-zero to the control unit for exception handling.

---
 rtl/div32_if.sv | 28 ++
 rtl/div32.sv | 141 ++++++++++++++
 tb/tb_div32.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div32_if.sv
// Operand/result bundle for the sequential signed divider.
// Handshake: the requester raises start for one cycle with dividend/divisor
// valid in that cycle. The divider accepts it only while idle (busy low or
// in the done cycle). Completion is a one-cycle done pulse, after which hi/lo
// hold the new result. A zero divisor gives a one-cycle div_zero pulse instead.
// start is not back-pressured; a start seen while the divider is working is
// dropped.
interface div32_if;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [1:0]  dbg_state;

  modport master (
    output start, dividend, divisor,
    input  hi, lo, busy, done, div_zero, dbg_state
  );

  modport slave (
    input  start, dividend, divisor,
    output hi, lo, busy, done, div_zero, dbg_state
  );
endinterface

// File: rtl/div32.sv
// Sequential signed 32-bit restoring divider, one quotient bit per cycle.
// Works on magnitudes and applies the signs in a final FIX cycle.
// hi = remainder (sign of dividend), lo = quotient (truncated toward zero).
module div32 (
  input  logic      clk,
  input  logic      reset,
  div32_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dz_q, dz_d;

  // Magnitudes of the operands; 0x80000000 maps onto itself as unsigned.
  logic [31:0] abs_dividend;
  logic [31:0] abs_divisor;
  // Partial remainder after the left shift, and the trial subtraction.
  logic [32:0] shifted;
  logic [32:0] trial;

  // Operand magnitudes and the trial subtraction for the current iteration.
  always_comb begin
    abs_dividend = bus.dividend[31] ? (32'd0 - bus.dividend) : bus.dividend;
    abs_divisor  = bus.divisor[31]  ? (32'd0 - bus.divisor)  : bus.divisor;
    shifted      = {rem_q, quo_q[31]};
    trial        = shifted - {1'b0, dvs_q};
  end

  // Next-state, datapath and output-pulse logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.divisor == 32'd0) begin
            dz_d = 1'b1;
          end else begin
            neg_quo_d = bus.dividend[31] ^ bus.divisor[31];
            neg_rem_d = bus.dividend[31];
            quo_d     = abs_dividend;
            dvs_d     = abs_divisor;
            rem_d     = 32'd0;
            cnt_d     = 6'd0;
            state_d   = S_CALC;
          end
        end
      end
      S_CALC: begin
        // The remainder is always below |divisor| <= 2^31, so the shifted
        // value fits in 32 bits and bit 32 of trial is a pure borrow.
        if (!trial[32]) begin
          rem_d = trial[31:0];
        end else begin
          rem_d = shifted[31:0];
        end
        quo_d = {quo_q[30:0], ~trial[32]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        lo_d    = neg_quo_q ? (32'd0 - quo_q) : quo_q;
        hi_d    = neg_rem_q ? (32'd0 - rem_q) : rem_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // busy covers CALC, FIX and the done cycle that follows FIX.
    busy_d = (state_d != S_IDLE) || done_d;
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvs_q     <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.div_zero  = dz_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_div32.sv
// Self-checking bench for div32: directed corner cases, randomized operands
// against an arithmetic reference model, divide-by-zero, reset abort,
// ignored starts while busy and back-to-back operation.
module tb_div32;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  div32_if bus();

  div32 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: signed division in 64-bit arithmetic, truncated to 32 bits.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lq = sa / sb;
    lr = sa % sb;
    q  = lq[31:0];
    r  = lr[31:0];
  endfunction

  // done and div_zero must never be high together.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (bus.done && bus.div_zero) begin
        errors++;
        $display("FAIL done_dz_overlap: done=%b div_zero=%b, required not both 1", bus.done, bus.div_zero);
      end
    end
  end

  // Driver: present a start with operands for one cycle (edge E), then
  // scramble the operand inputs so any re-read would corrupt the result.
  task automatic kick(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
  endtask

  // Sample once per cycle (#1 after each edge) until done or budget expires.
  // lat = number of edges after E at which done was first seen.
  task automatic wait_done(output int lat, output int bcnt, output logic got);
    lat  = -1;
    bcnt = 0;
    got  = 1'b0;
    for (int k = 0; k <= 60; k++) begin
      if (bus.busy) bcnt++;
      if (bus.done) begin
        got = 1'b1;
        lat = k;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    bus.start    = 1'b0;
    bus.dividend = 32'd0;
    bus.divisor  = 32'd0;
    reset        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_hilo: hi=%h lo=%h, required 0/0", bus.hi, bus.lo);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b dz=%b, required 0", bus.busy, bus.done, bus.div_zero);
    end
    checks++;
    if (bus.dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: state=%0d, required 0", bus.dbg_state);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] ta [7];
    logic [31:0] tb [7];
    logic [31:0] tq [7];
    logic [31:0] tr [7];
    int lat, bcnt;
    logic got;
    ta = '{32'd7, 32'hFFFFFFF9, 32'd7,        32'h80000000, 32'h80000000, 32'd0, 32'd5};
    tb = '{32'd2, 32'd2,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1,        32'd5, 32'h80000000};
    tq = '{32'd3, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'h80000000, 32'd0, 32'd0};
    tr = '{32'd1, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        32'd0, 32'd5};
    for (int i = 0; i < 7; i++) begin
      kick(ta[i], tb[i]);
      wait_done(lat, bcnt, got);
      checks++;
      if (!got || lat != 33) begin
        errors++;
        $display("FAIL dir_latency[%0d]: done_seen=%b edges=%0d, required 1/33", i, got, lat);
      end
      checks++;
      if (bus.lo !== tq[i] || bus.hi !== tr[i]) begin
        errors++;
        $display("FAIL dir_result[%0d] %h/%h: lo=%h hi=%h, required lo=%h hi=%h",
                 i, ta[i], tb[i], bus.lo, bus.hi, tq[i], tr[i]);
      end
      checks++;
      if (bcnt != 34) begin
        errors++;
        $display("FAIL dir_busy_len[%0d]: busy cycles=%0d, required 34", i, bcnt);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL dir_after_done[%0d]: busy=%b done=%b, required 0/0", i, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, eq, er;
    int lat, bcnt, mode;
    logic got;
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 3);
      a = $urandom;
      b = $urandom;
      if (mode == 1) b = $urandom_range(1, 15);
      if (mode == 2) b = 32'd0 - 32'($urandom_range(1, 15));
      if (mode == 3) a = 32'h80000000;
      if (b == 32'd0) b = 32'd1;
      ref_div(a, b, eq, er);
      kick(a, b);
      wait_done(lat, bcnt, got);
      checks++;
      if (!got || lat != 33) begin
        errors++;
        $display("FAIL rnd_latency[%0d]: done_seen=%b edges=%0d, required 1/33", i, got, lat);
      end
      checks++;
      if (bus.lo !== eq || bus.hi !== er) begin
        errors++;
        $display("FAIL rnd_result[%0d] %h/%h: lo=%h hi=%h, required lo=%h hi=%h",
                 i, a, b, bus.lo, bus.hi, eq, er);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat, bcnt;
    logic got;
    kick(32'd7, 32'hFFFFFFFE);
    wait_done(lat, bcnt, got);
    checks++;
    if (bus.lo !== 32'hFFFFFFFD || bus.hi !== 32'd1) begin
      errors++;
      $display("FAIL dz_setup: lo=%h hi=%h, required FFFFFFFD/00000001", bus.lo, bus.hi);
    end
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd1234;
    bus.divisor  = 32'd0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++;
    if (bus.div_zero !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL dz_pulse: dz=%b busy=%b done=%b, required 1/0/0", bus.div_zero, bus.busy, bus.done);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.div_zero !== 1'b0) begin
      errors++;
      $display("FAIL dz_width: dz=%b one cycle later, required 0", bus.div_zero);
    end
    wait_done(lat, bcnt, got);
    checks++;
    if (got || bcnt != 0) begin
      errors++;
      $display("FAIL dz_no_done: done_seen=%b busy cycles=%0d, required 0/0", got, bcnt);
    end
    checks++;
    if (bus.lo !== 32'hFFFFFFFD || bus.hi !== 32'd1) begin
      errors++;
      $display("FAIL dz_hold: lo=%h hi=%h, required FFFFFFFD/00000001", bus.lo, bus.hi);
    end
  endtask

  task automatic test_reset_mid_calc();
    int lat, bcnt;
    logic got;
    kick(32'd7, 32'd2);
    wait_done(lat, bcnt, got);
    checks++;
    if (bus.lo !== 32'd3 || bus.hi !== 32'd1) begin
      errors++;
      $display("FAIL rst_setup: lo=%h hi=%h, required 3/1", bus.lo, bus.hi);
    end
    kick(32'd123456, 32'd789);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort: hi=%h lo=%h busy=%b done=%b, required 0/0/0/0",
               bus.hi, bus.lo, bus.busy, bus.done);
    end
    checks++;
    if (bus.dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL rst_abort_state: state=%0d, required 0", bus.dbg_state);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    wait_done(lat, bcnt, got);
    checks++;
    if (got) begin
      errors++;
      $display("FAIL rst_no_done: done_seen=%b at %0d, required none", got, lat);
    end
    kick(32'hFFFFFF9C, 32'd7);
    wait_done(lat, bcnt, got);
    checks++;
    if (!got || lat != 33 || bus.lo !== 32'hFFFFFFF2 || bus.hi !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL rst_fresh: done_seen=%b edges=%0d lo=%h hi=%h, required 1/33/FFFFFFF2/FFFFFFFE",
               got, lat, bus.lo, bus.hi);
    end
  endtask

  // Starts held high throughout the busy period are dropped; the start
  // presented in the done cycle is accepted (back-to-back).
  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, eq, er;
    int lat, bcnt;
    logic got;
    a1 = $urandom;
    b1 = $urandom_range(1, 1000);
    a2 = $urandom;
    b2 = 32'd0 - 32'($urandom_range(1, 1000));
    kick(a1, b1);
    bus.start = 1'b1;
    got = 1'b0;
    lat = -1;
    for (int k = 0; k <= 60; k++) begin
      if (bus.done) begin
        got = 1'b1;
        lat = k;
        break;
      end
      @(posedge clk);
      #1;
      bus.dividend = $urandom;
      bus.divisor  = $urandom;
    end
    ref_div(a1, b1, eq, er);
    checks++;
    if (!got || lat != 33) begin
      errors++;
      $display("FAIL busy_start_latency: done_seen=%b edges=%0d, required 1/33", got, lat);
    end
    checks++;
    if (bus.lo !== eq || bus.hi !== er) begin
      errors++;
      $display("FAIL busy_start_result: lo=%h hi=%h, required lo=%h hi=%h", bus.lo, bus.hi, eq, er);
    end
    bus.dividend = a2;
    bus.divisor  = b2;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b after start in done cycle, required 1", bus.busy);
    end
    wait_done(lat, bcnt, got);
    ref_div(a2, b2, eq, er);
    checks++;
    if (!got || lat != 33 || bus.lo !== eq || bus.hi !== er) begin
      errors++;
      $display("FAIL b2b_result: done_seen=%b edges=%0d lo=%h hi=%h, required 1/33 lo=%h hi=%h",
               got, lat, bus.lo, bus.hi, eq, er);
    end
  endtask

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_random();
    test_div_zero();
    test_reset_mid_calc();
    test_back_to_back();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
